// File: rtl/vdu_mem_arbiter.sv
// vdu_mem_arbiter
// Shares one single-port synchronous RAM between the Mk14 CPU bus and the VDU
// line fetcher. VDU reads always win the address port and carry no handshake.
// CPU accesses use a req/ack handshake and are held off while the VDU owns the
// port. The block also counts CPU stall cycles and flags request starvation.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cpu_req/we/addr/wdata  CPU request, held until o_cpu_ack
//   o_cpu_rdata, o_cpu_ack   CPU read data (held) and one-cycle completion pulse
//   i_vdu_read_en/addr    VDU owns the RAM port this cycle / VDU read address
//   o_vdu_data            RAM read data passed straight to the VDU
//   o_mem_addr/we/wdata   RAM port, i_mem_rdata returns one cycle after address
//   i_stat_clr            clears o_stall_cnt and o_starve
//   o_stall_cnt, o_starve saturating stall count, sticky starvation flag
//   o_dbg_state           current FSM state for observation
//
// Handshake: a CPU request is presented by holding i_cpu_req high with stable
// we/addr/wdata; it completes in the single cycle o_cpu_ack is high. If req is
// still high in the cycle after that ack it is taken as a new request.
module vdu_mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_ack,
    input  logic          i_vdu_read_en,
    input  logic [AW-1:0] i_vdu_read_addr,
    output logic [DW-1:0] o_vdu_data,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_stat_clr,
    output logic [15:0]   o_stall_cnt,
    output logic          o_starve,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RDATA = 2'd1,
        S_WACK  = 2'd2
    } state_t;

    localparam logic [15:0] MAX_WAIT_W = 16'(MAX_WAIT);
    localparam logic [15:0] SAT        = 16'hFFFF;

    state_t        state_q;
    logic          cpu_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic [15:0]   wait_q, wait_d;
    logic          starve_q, starve_d;

    logic cpu_pending;
    logic cpu_grant;
    logic cpu_stall;

    // A read completes with its ack in S_IDLE; while that ack is showing the
    // still-high req belongs to the finished access and must not restart it.
    assign cpu_pending = (state_q == S_IDLE) && i_cpu_req && !cpu_ack_q && !i_rst;
    assign cpu_grant   = cpu_pending && !i_vdu_read_en;
    assign cpu_stall   = cpu_pending &&  i_vdu_read_en;

    // RAM port mux: VDU first, CPU only during its granted address phase.
    always_comb begin
        o_mem_addr  = i_cpu_addr;
        o_mem_we    = 1'b0;
        o_mem_wdata = i_cpu_wdata;
        if (i_vdu_read_en) begin
            o_mem_addr = i_vdu_read_addr;
        end else if (cpu_grant) begin
            o_mem_we = i_cpu_we;
        end
    end

    assign o_vdu_data = i_mem_rdata;

    // Statistics next state; a clear in the same cycle as a stall wins.
    always_comb begin
        wait_d = wait_q;
        if (cpu_grant) begin
            wait_d = '0;
        end else if (cpu_stall && (wait_q != SAT)) begin
            wait_d = wait_q + 16'd1;
        end

        stall_cnt_d = stall_cnt_q;
        starve_d    = starve_q;
        if (i_stat_clr) begin
            stall_cnt_d = '0;
            starve_d    = 1'b0;
        end else if (cpu_stall) begin
            if (stall_cnt_q != SAT) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (wait_d >= MAX_WAIT_W) begin
                starve_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            stall_cnt_q <= '0;
            wait_q      <= '0;
            starve_q    <= 1'b0;
        end else begin
            cpu_ack_q   <= 1'b0;
            stall_cnt_q <= stall_cnt_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            case (state_q)
                S_IDLE: begin
                    if (cpu_grant) begin
                        // Writes commit in this cycle, so their ack is next cycle.
                        state_q   <= i_cpu_we ? S_WACK : S_RDATA;
                        cpu_ack_q <= i_cpu_we;
                    end
                end
                S_RDATA: begin
                    // RAM data for the address phase is on i_mem_rdata now;
                    // the VDU may be using the address port meanwhile.
                    cpu_rdata_q <= i_mem_rdata;
                    cpu_ack_q   <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_WACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_ack   = cpu_ack_q;
    assign o_cpu_rdata = cpu_rdata_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_starve    = starve_q;
    assign o_dbg_state = 2'(state_q);

endmodule
